// File: rtl/mmio_pkg.sv
// Shared address map, status field positions and region decode for mmio_responder.
package mmio_pkg;

   localparam logic [31:0] CONSOLE_DATA_ADDR   = 32'hFFFF_0000;
   localparam logic [31:0] CONSOLE_STATUS_ADDR = 32'hFFFF_0004;
   localparam logic [31:0] CYCLE_ADDR          = 32'hFFFF_0008;
   localparam logic [31:0] TOHOST_ADDR         = 32'hFFFF_000C;

   localparam int unsigned STATUS_FULL_BIT  = 0;
   localparam int unsigned STATUS_EMPTY_BIT = 1;
   localparam int unsigned STATUS_OVF_BIT   = 2;
   localparam int unsigned STATUS_COUNT_LSB = 8;

   typedef enum logic [2:0] {
      RAM,
      CONSOLE_DATA,
      CONSOLE_STATUS,
      CYCLE,
      TOHOST,
      UNMAPPED
   } region_e;

   // Decodes a word index (byte address >> 2); RAM occupies the lowest ram_words words.
   function automatic region_e decode_region(input logic [29:0] word_idx,
                                             input int unsigned ram_words);
      region_e r;
      r = UNMAPPED;
      if ({2'b00, word_idx} < ram_words)              r = RAM;
      else if (word_idx == CONSOLE_DATA_ADDR[31:2])   r = CONSOLE_DATA;
      else if (word_idx == CONSOLE_STATUS_ADDR[31:2]) r = CONSOLE_STATUS;
      else if (word_idx == CYCLE_ADDR[31:2])          r = CYCLE;
      else if (word_idx == TOHOST_ADDR[31:2])         r = TOHOST;
      return r;
   endfunction

endpackage

// File: rtl/mmio_responder_console_fifo.sv
// Console byte FIFO: wrap-around read/write pointers plus an explicit occupancy count.
module console_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [7:0]                 din_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [7:0]                 head_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/mmio_responder.sv
// M-stage data responder: RAM plus console FIFO, cycle counter and halt registers.
// Optional cycle counter enabled by defining MMIO_CYCLE_COUNTER_EN.
module mmio_responder
   import mmio_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        MemWrite,
   output logic [31:0] RD,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done,
   output logic [31:0] tohost
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   region_e       region;
   logic [31:0]   ram_q [DEPTH_WORDS];
   logic [AW-1:0] ram_idx;
   logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_head;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic [31:0]   tohost_q, tohost_d;
   logic [31:0]   status_rd, cycle_rd;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^A[1:0];
   assign region  = decode_region(A[31:2], DEPTH_WORDS);
   assign ram_idx = A[AW+1:2];

   always_ff @(posedge clk) begin
      if (MemWrite && region == RAM) ram_q[ram_idx] <= WD;
   end

   assign fifo_push = MemWrite && region == CONSOLE_DATA;
   assign fifo_pop  = tx_valid & tx_ready;

   console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (fifo_push),
      .din_i   (WD[7:0]),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign tx_valid = ~fifo_empty;
   assign tx_data  = fifo_head;

   always_comb begin
      ovf_d    = ovf_q;
      done_d   = done_q;
      tohost_d = tohost_q;
      if (MemWrite && region == CONSOLE_STATUS) ovf_d = 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
      if (MemWrite && region == TOHOST && !done_q && WD != '0) begin
         done_d   = 1'b1;
         tohost_d = WD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         tohost_q <= '0;
      end else begin
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         tohost_q <= tohost_d;
      end
   end

   assign done   = done_q;
   assign tohost = tohost_q;

`ifdef MMIO_CYCLE_COUNTER_EN
   logic [31:0] cycle_q, cycle_d;

   // Frozen entirely (including loads) once the program has halted.
   always_comb begin
      cycle_d = cycle_q;
      if (!done_q) cycle_d = (MemWrite && region == CYCLE) ? WD : cycle_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cycle_q <= '0;
      else       cycle_q <= cycle_d;
   end

   assign cycle_rd = cycle_q;
`else
   assign cycle_rd = '0;
`endif

   always_comb begin
      status_rd                        = '0;
      status_rd[STATUS_FULL_BIT]       = fifo_full;
      status_rd[STATUS_EMPTY_BIT]      = fifo_empty;
      status_rd[STATUS_OVF_BIT]        = ovf_q;
      status_rd[STATUS_COUNT_LSB +: 8] = 8'(fifo_count);
   end

   always_comb begin
      RD = '0;
      case (region)
         RAM:            RD = ram_q[ram_idx];
         CONSOLE_DATA:   RD = {24'b0, fifo_head};
         CONSOLE_STATUS: RD = status_rd;
         CYCLE:          RD = cycle_rd;
         TOHOST:         RD = tohost_q;
         default:        RD = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized + directed bench for mmio_responder against a transaction-level model.
module tb_mmio_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, WD, RD, tohost;
   logic        MemWrite, tx_ready, tx_valid, done;
   logic [7:0]  tx_data;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   logic [31:0] ram_m [int];
   byte unsigned fifo_m [$];
   bit          ovf_m;
   logic [31:0] cyc_m;
   bit          done_m;
   logic [31:0] tohost_m;

   always #5 clk = ~clk;

   mmio_responder #(.DEPTH_WORDS(256), .FIFO_DEPTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .A        (A),
      .WD       (WD),
      .MemWrite (MemWrite),
      .RD       (RD),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .done     (done),
      .tohost   (tohost)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      fifo_m.delete();
      ovf_m    = 0;
      cyc_m    = 0;
      done_m   = 0;
      tohost_m = 0;
   endfunction

   function automatic logic [31:0] waddr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   function automatic void exp_rd(input logic [31:0] a, output logic [31:0] v, output bit known);
      int unsigned widx;
      widx  = int'(a >> 2);
      known = 1;
      v     = 0;
      if (widx < 256) begin
         if (ram_m.exists(widx)) v = ram_m[widx];
         else known = 0;
      end else if (waddr(a) == 32'hFFFF_0000) v = fifo_m.size() ? 32'(fifo_m[0]) : 0;
      else if (waddr(a) == 32'hFFFF_0004)
         v = fifo_m.size() * 256 + (ovf_m ? 4 : 0) + (fifo_m.size() == 0 ? 2 : 0)
             + (fifo_m.size() == 8 ? 1 : 0);
      else if (waddr(a) == 32'hFFFF_0008) begin
`ifdef MMIO_CYCLE_COUNTER_EN
         v = cyc_m;
`else
         v = 0;
`endif
      end else if (waddr(a) == 32'hFFFF_000C) v = tohost_m;
   endfunction

   // One clock: drive, compare everything at negedge, then advance the model across the edge.
   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
      logic [31:0] v;
      bit          known, pop, push_ok;
      A = a; WD = wd; MemWrite = we; tx_ready = rdy;
      @(negedge clk);
      exp_rd(a, v, known);
      if (known) check_eq("rd", RD, v);
      check_eq("tx_valid", 32'(tx_valid), 32'(fifo_m.size() != 0));
      check_eq("tx_data", 32'(tx_data), fifo_m.size() ? 32'(fifo_m[0]) : 0);
      check_eq("done", 32'(done), 32'(done_m));
      check_eq("tohost", tohost, tohost_m);
      @(posedge clk);
      pop     = (fifo_m.size() != 0) && rdy;
      push_ok = 0;
      if (!done_m) cyc_m = (we && waddr(a) == 32'hFFFF_0008) ? wd : cyc_m + 1;
      if (we) begin
         if ((a >> 2) < 256) ram_m[int'(a >> 2)] = wd;
         else if (waddr(a) == 32'hFFFF_0000) begin
            if (fifo_m.size() < 8 || pop) push_ok = 1;
            else ovf_m = 1;
         end else if (waddr(a) == 32'hFFFF_0004) ovf_m = 0;
         else if (waddr(a) == 32'hFFFF_000C && !done_m && wd != 0) begin
            done_m   = 1;
            tohost_m = wd;
         end
      end
      if (pop) void'(fifo_m.pop_front());
      if (push_ok) fifo_m.push_back(wd[7:0]);
      #1;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] v);
      A = a; MemWrite = 0;
      #1;
      v = RD;
   endtask

   task automatic rand_step(input bit allow_halt);
      logic [31:0] a, wd;
      logic        we;
      case ($urandom_range(0, 9))
         0, 1, 2, 3: a = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
         4, 5:       a = 32'hFFFF_0000;
         6:          a = 32'hFFFF_0004;
         7:          a = 32'hFFFF_0008;
         8:          a = allow_halt ? 32'hFFFF_000C : 32'h0000_0800 + ($urandom & 32'hFFC);
         default:    a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_0010 + ($urandom & 32'h3C) : 32'h0000_0400;
      endcase
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 32'hFFFF_000C && $urandom_range(0, 15) != 0) wd = 0;
      step(a, wd, we, 1'($urandom_range(0, 1)));
   endtask

   task automatic do_reset();
      reset = 1; MemWrite = 0; tx_ready = 0; A = 0; WD = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      model_reset();
   endtask

   logic [31:0] v, v2;

   initial begin
      do_reset();
      check_eq("rst_tx_valid", 32'(tx_valid), 0);
      check_eq("rst_tx_data", 32'(tx_data), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_tohost", tohost, 0);
      peek(32'hFFFF_0004, v);
      check_eq("rst_status", v, 32'h0000_0002);

      // RAM store and unaligned / out-of-range reads
      step(32'h0000_0020, 32'hDEAD_BEEF, 1, 0);
      peek(32'h0000_0023, v);
      check_eq("ram_rd", v, 32'hDEAD_BEEF);
      peek(32'h0000_0800, v);
      check_eq("ram_oob", v, 0);

      // Console push and delivery
      step(32'hFFFF_0000, 32'h0000_0048, 1, 0);
      step(32'hFFFF_0000, 32'hABCD_0069, 1, 0);
      peek(32'hFFFF_0004, v);
      check_eq("con_status2", v, 32'h0000_0200);
      check_eq("con_head_h", 32'(tx_data), 32'h48);
      step(32'h0000_0800, 0, 0, 1);
      check_eq("con_head_i", 32'(tx_data), 32'h69);
      step(32'h0000_0800, 0, 0, 1);
      check_eq("con_empty_valid", 32'(tx_valid), 0);
      peek(32'hFFFF_0004, v);
      check_eq("con_empty_status", v, 32'h0000_0002);

      // Overflow, status clear, push+pop while full
      for (int i = 0; i < 9; i++) step(32'hFFFF_0000, 32'(8'h30 + i), 1, 0);
      peek(32'hFFFF_0004, v);
      check_eq("ovf_status", v, 32'h0000_0805);
      step(32'hFFFF_0004, 32'h1234_5678, 1, 0);
      peek(32'hFFFF_0004, v);
      check_eq("ovf_cleared", v, 32'h0000_0801);
      step(32'hFFFF_0000, 32'h0000_005A, 1, 1);
      peek(32'hFFFF_0004, v);
      check_eq("full_pushpop", v, 32'h0000_0801);
      for (int i = 0; i < 9; i++) step(32'h0000_0800, 0, 0, 1);

      // Cycle counter load and wrap
      step(32'hFFFF_0008, 32'hFFFF_FFFE, 1, 0);
      step(32'h0000_0800, 0, 0, 0);
      peek(32'hFFFF_0008, v);
`ifdef MMIO_CYCLE_COUNTER_EN
      check_eq("cycle_ffff", v, 32'hFFFF_FFFF);
`else
      check_eq("cycle_off", v, 0);
`endif
      step(32'h0000_0800, 0, 0, 0);
      peek(32'hFFFF_0008, v);
      check_eq("cycle_wrap", v, 0);

      for (int i = 0; i < 1500; i++) rand_step(0);

      // Halt handling
      step(32'h0000_0020, 32'hDEAD_BEEF, 1, 0);
      for (int i = 0; i < 10; i++) step(32'h0000_0800, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(32'hFFFF_0000, 32'(8'h41 + i), 1, 0);
      step(32'hFFFF_000C, 0, 1, 0);
      check_eq("halt_zero", 32'(done), 0);
      step(32'hFFFF_000C, 1, 1, 0);
      check_eq("halt_done", 32'(done), 1);
      check_eq("halt_tohost", tohost, 1);
      step(32'hFFFF_000C, 5, 1, 0);
      check_eq("halt_sticky", tohost, 1);
      peek(32'hFFFF_0008, v);
      step(32'h0000_0800, 0, 0, 0);
      peek(32'hFFFF_0008, v2);
      check_eq("cycle_frozen", v2, v);

      // Asynchronous reset mid-operation
      A = 32'hFFFF_0004;
      #2 reset = 1;
      #1;
      check_eq("arst_tx_valid", 32'(tx_valid), 0);
      check_eq("arst_done", 32'(done), 0);
      check_eq("arst_tohost", tohost, 0);
      check_eq("arst_status", RD, 32'h0000_0002);
      A = 32'h0000_0020;
      #1;
      check_eq("arst_ram", RD, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      reset = 0;
      model_reset();

      for (int i = 0; i < 1500; i++) rand_step(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
